// File: rtl/spi_cmd_sequencer_if.sv
// SPI host pins plus the toggle-qualified write/start handoff toward the system clock domain.
interface spi_cmd_sequencer_if #(
  parameter int ADDR_W = 4,
  parameter int ELEM_W = 16
);
  logic              cs_n;
  logic              mosi;
  logic              miso;
  logic              busy;
  logic              wr_tgl;
  logic              wr_sel;
  logic [ADDR_W-1:0] wr_addr;
  logic [ELEM_W-1:0] wr_data;
  logic              start_tgl;

  modport master (
    output cs_n, mosi, busy,
    input  miso, wr_tgl, wr_sel, wr_addr, wr_data, start_tgl
  );

  modport slave (
    input  cs_n, mosi, busy,
    output miso, wr_tgl, wr_sel, wr_addr, wr_data, start_tgl
  );
endinterface

// File: rtl/spi_cmd_sequencer.sv
// SCLK-domain SPI command decoder: loads A/B matrix elements, issues START and serves a status byte.
// Frame-local state is cleared asynchronously by cs_n high; published outputs and flags survive frames.
module spi_cmd_sequencer #(
  parameter int ELEM_W = 16,
  parameter int N_ELEM = 16,
  parameter int ADDR_W = 4
) (
  input logic                 sclk,
  input logic                 rst_n,
  spi_cmd_sequencer_if.slave  bus
);
  localparam logic [ADDR_W:0] LAST_ELEM = (ADDR_W+1)'(N_ELEM - 1);
  localparam logic [ADDR_W:0] FULL_ELEM = (ADDR_W+1)'(N_ELEM);

  typedef enum logic [1:0] {ST_CMD, ST_LOAD, ST_STAT, ST_IGNORE} state_t;

  state_t            state, next_state;
  logic              frame_clr;
  logic [2:0]        bit_cnt;
  logic [6:0]        rx_shift;
  logic [7:0]        rx_byte;
  logic              byte_done;
  logic              byte_idx;
  logic [ADDR_W:0]   elem_idx;
  logic [7:0]        low_byte;
  logic              load_sel;
  logic              load_complete;
  logic [7:0]        stat_byte;
  logic [3:0]        stat_cnt;
  logic              miso_q;

  logic              busy_meta, busy_sync;
  logic              err, a_done, b_done;
  logic              wr_tgl_q, wr_sel_q, start_tgl_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [ELEM_W-1:0] wr_data_q;

  logic pub_elem, set_err, clr_err, start_flip, snap;
  logic clr_a, clr_b, set_a, set_b;

  assign frame_clr = ~rst_n | bus.cs_n;
  assign byte_done = (bit_cnt == 3'd7);
  assign rx_byte   = {rx_shift, bus.mosi};

  always_comb begin
    next_state = state;
    pub_elem   = 1'b0;
    set_err    = 1'b0;
    clr_err    = 1'b0;
    start_flip = 1'b0;
    snap       = 1'b0;
    clr_a      = 1'b0;
    clr_b      = 1'b0;
    set_a      = 1'b0;
    set_b      = 1'b0;
    if (byte_done) begin
      case (state)
        ST_CMD: begin
          case (rx_byte)
            8'h10: begin next_state = ST_LOAD; clr_a = 1'b1; end
            8'h20: begin next_state = ST_LOAD; clr_b = 1'b1; end
            8'h30: begin
              next_state = ST_IGNORE;
              if (busy_sync) set_err = 1'b1;
              else           start_flip = 1'b1;
            end
            8'h40: begin next_state = ST_STAT; snap = 1'b1; clr_err = 1'b1; end
            default: begin next_state = ST_IGNORE; set_err = 1'b1; end
          endcase
        end
        ST_LOAD: begin
          if (byte_idx) begin
            pub_elem = 1'b1;
            if (elem_idx == LAST_ELEM) begin
              next_state = ST_IGNORE;
              set_a      = ~load_sel;
              set_b      = load_sel;
            end
          end
        end
        ST_STAT:   ;
        ST_IGNORE: set_err = load_complete;
        default:   next_state = ST_CMD;
      endcase
    end
  end

  always_ff @(posedge sclk or posedge frame_clr) begin
    if (frame_clr) begin
      state         <= ST_CMD;
      bit_cnt       <= '0;
      rx_shift      <= '0;
      byte_idx      <= 1'b0;
      elem_idx      <= '0;
      low_byte      <= '0;
      load_sel      <= 1'b0;
      load_complete <= 1'b0;
      stat_byte     <= '0;
    end else begin
      state    <= next_state;
      bit_cnt  <= bit_cnt + 3'd1;
      rx_shift <= {rx_shift[5:0], bus.mosi};
      if (byte_done && state == ST_CMD)
        load_sel <= (rx_byte == 8'h20);
      if (byte_done && state == ST_LOAD) begin
        byte_idx <= ~byte_idx;
        if (!byte_idx) low_byte <= rx_byte;
      end
      if (pub_elem && elem_idx != FULL_ELEM)
        elem_idx <= elem_idx + 1'b1;
      if (set_a || set_b)
        load_complete <= 1'b1;
      if (snap)
        stat_byte <= {busy_sync, err, a_done, b_done, 4'b0000};
    end
  end

  // Status bits leave on falling edges so the host samples each one on its next rising edge.
  always_ff @(negedge sclk or posedge frame_clr) begin
    if (frame_clr) begin
      miso_q   <= 1'b0;
      stat_cnt <= '0;
    end else if (state == ST_STAT && stat_cnt != 4'd8) begin
      miso_q   <= stat_byte[~stat_cnt[2:0]];
      stat_cnt <= stat_cnt + 4'd1;
    end else begin
      miso_q <= 1'b0;
    end
  end

  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      busy_meta   <= 1'b0;
      busy_sync   <= 1'b0;
      err         <= 1'b0;
      a_done      <= 1'b0;
      b_done      <= 1'b0;
      wr_tgl_q    <= 1'b0;
      wr_sel_q    <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      start_tgl_q <= 1'b0;
    end else begin
      busy_meta <= bus.busy;
      busy_sync <= busy_meta;
      if (clr_err)      err <= 1'b0;
      else if (set_err) err <= 1'b1;
      if (clr_a)        a_done <= 1'b0;
      else if (set_a)   a_done <= 1'b1;
      if (clr_b)        b_done <= 1'b0;
      else if (set_b)   b_done <= 1'b1;
      if (pub_elem) begin
        wr_data_q <= {rx_byte, low_byte};
        wr_addr_q <= elem_idx[ADDR_W-1:0];
        wr_sel_q  <= load_sel;
        wr_tgl_q  <= ~wr_tgl_q;
      end
      if (start_flip) start_tgl_q <= ~start_tgl_q;
    end
  end

  assign bus.miso      = miso_q;
  assign bus.wr_tgl    = wr_tgl_q;
  assign bus.wr_sel    = wr_sel_q;
  assign bus.wr_addr   = wr_addr_q;
  assign bus.wr_data   = wr_data_q;
  assign bus.start_tgl = start_tgl_q;
endmodule

// File: tb/tb_spi_cmd_sequencer.sv
// Directed and randomized SPI frames against a byte-level model of the command sequencer.
module tb_spi_cmd_sequencer;
  localparam int N_ELEM = 16;

  typedef logic [7:0] u8_t;

  logic sclk;
  logic rst_n;

  spi_cmd_sequencer_if bus ();

  spi_cmd_sequencer dut (
    .sclk  (sclk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial sclk = 1'b0;
  always #5 sclk = ~sclk;

  int errors = 0;
  int checks = 0;

  logic        m_err, m_a, m_b, m_busy, m_sel;
  logic [3:0]  m_addr;
  logic [15:0] m_data;
  logic [7:0]  m_stat;
  int          m_wr_flips, m_start_flips;

  int   obs_wr_flips, obs_start_flips;
  logic prev_wr, prev_start;

  // Count toggle edges seen on the pins so double flips or missed flips are caught.
  always @(negedge sclk) begin
    if (!rst_n) begin
      obs_wr_flips    = 0;
      obs_start_flips = 0;
      prev_wr         = 1'b0;
      prev_start      = 1'b0;
    end else begin
      if (bus.wr_tgl !== prev_wr)       obs_wr_flips++;
      if (bus.start_tgl !== prev_start) obs_start_flips++;
      prev_wr    = bus.wr_tgl;
      prev_start = bus.start_tgl;
    end
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    m_err = 0; m_a = 0; m_b = 0; m_sel = 0; m_addr = 0; m_data = 0;
    m_stat = 0; m_wr_flips = 0; m_start_flips = 0;
  endfunction

  // Whole-frame effect: elements are byte pairs after the command, capped at one matrix.
  function automatic void model_frame(input u8_t f[$]);
    int   pairs;
    logic sel;
    if (f.size() == 0) return;
    case (f[0])
      8'h10, 8'h20: begin
        sel = (f[0] == 8'h20);
        if (sel) m_b = 0; else m_a = 0;
        pairs = (f.size() - 1) / 2;
        if (pairs > N_ELEM) pairs = N_ELEM;
        for (int k = 0; k < pairs; k++) begin
          m_sel  = sel;
          m_addr = 4'(k);
          m_data = {f[2*k+2], f[2*k+1]};
          m_wr_flips++;
        end
        if (pairs == N_ELEM) begin
          if (sel) m_b = 1; else m_a = 1;
          if (f.size() - 1 > 2 * N_ELEM) m_err = 1;
        end
      end
      8'h30: begin
        if (m_busy) m_err = 1;
        else        m_start_flips++;
      end
      8'h40: begin
        m_stat = {m_busy, m_err, m_a, m_b, 4'b0000};
        m_err  = 0;
      end
      default: m_err = 1;
    endcase
  endfunction

  task automatic send_byte(input u8_t b, output u8_t r);
    for (int i = 7; i >= 0; i--) begin
      bus.mosi = b[i];
      @(posedge sclk);
      r[i] = bus.miso;
      @(negedge sclk);
    end
  endtask

  task automatic apply_stimulus(input u8_t f[$], output u8_t rx[$]);
    u8_t r;
    rx = {};
    @(negedge sclk);
    bus.cs_n = 1'b0;
    foreach (f[j]) begin
      send_byte(f[j], r);
      rx.push_back(r);
    end
    bus.cs_n = 1'b1;
    bus.mosi = 1'b0;
    repeat (2) @(negedge sclk);
  endtask

  task automatic check_state(input string tag);
    check_output({tag, ".wr_tgl"},    32'(bus.wr_tgl),    32'(m_wr_flips % 2));
    check_output({tag, ".wr_sel"},    32'(bus.wr_sel),    32'(m_sel));
    check_output({tag, ".wr_addr"},   32'(bus.wr_addr),   32'(m_addr));
    check_output({tag, ".wr_data"},   32'(bus.wr_data),   32'(m_data));
    check_output({tag, ".start_tgl"}, 32'(bus.start_tgl), 32'(m_start_flips % 2));
    check_output({tag, ".wr_flips"},  32'(obs_wr_flips),  32'(m_wr_flips));
    check_output({tag, ".st_flips"},  32'(obs_start_flips), 32'(m_start_flips));
    check_output({tag, ".miso_idle"}, 32'(bus.miso),      32'(0));
  endtask

  task automatic run_frame(input string tag, input u8_t f[$]);
    u8_t rx[$];
    apply_stimulus(f, rx);
    model_frame(f);
    check_state(tag);
    if (f.size() >= 2 && f[0] == 8'h40)
      check_output({tag, ".status"}, 32'(rx[1]), 32'(m_stat));
    if (f.size() >= 3 && f[0] == 8'h40)
      check_output({tag, ".miso_after"}, 32'(rx[2]), 32'(0));
  endtask

  task automatic set_busy(input logic v);
    bus.busy = v;
    repeat (4) @(negedge sclk);
    m_busy = v;
  endtask

  function automatic void make_load(input u8_t cmd, input int n_data, output u8_t f[$]);
    f = {cmd};
    for (int k = 0; k < n_data; k++) begin
      if (k % 2 == 0) f.push_back(u8_t'(k / 2));
      else            f.push_back(8'h01);
    end
  endfunction

  initial begin
    u8_t f[$];
    u8_t r;
    u8_t cmd;
    int  tail;
    rst_n    = 1'b0;
    bus.cs_n = 1'b1;
    bus.mosi = 1'b0;
    bus.busy = 1'b0;
    m_busy   = 1'b0;
    model_reset();
    repeat (3) @(negedge sclk);
    check_state("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge sclk);

    run_frame("loadA_e0", '{8'h10, 8'h01, 8'h00});
    check_output("loadA_e0.const", 32'(bus.wr_data), 32'h0001);

    make_load(8'h20, 33, f);
    run_frame("loadB_full", f);
    check_output("loadB_full.addr_const", 32'(bus.wr_addr), 32'd15);
    check_output("loadB_full.data_const", 32'(bus.wr_data), 32'h010F);
    run_frame("loadB_full.stat", '{8'h40, 8'h00, 8'h00});

    run_frame("abort", '{8'h10, 8'h34});
    run_frame("abort_next", '{8'h10, 8'h34, 8'h12});
    check_output("abort_next.const", 32'(bus.wr_data), 32'h1234);

    run_frame("start_idle", '{8'h30});
    set_busy(1'b1);
    run_frame("start_busy", '{8'h30});
    run_frame("start_busy.stat", '{8'h40, 8'h00});
    set_busy(1'b0);

    run_frame("illegal", '{8'h55, 8'h10, 8'h00});
    run_frame("illegal.stat", '{8'h40, 8'h00});

    // Reset arrives with a half-received element still inside the frame.
    @(negedge sclk);
    bus.cs_n = 1'b0;
    send_byte(8'h10, r);
    send_byte(8'h01, r);
    rst_n = 1'b0;
    model_reset();
    @(negedge sclk);
    check_state("mid_reset");
    bus.cs_n = 1'b1;
    @(negedge sclk);
    rst_n = 1'b1;
    repeat (2) @(negedge sclk);
    run_frame("post_reset", '{8'h10, 8'h77, 8'h66});

    set_busy(1'b1);
    run_frame("err_start", '{8'h30});
    set_busy(1'b0);
    make_load(8'h10, 32, f);
    run_frame("loadA_full", f);
    apply_stimulus('{8'h40, 8'h00}, f);
    model_frame('{8'h40, 8'h00});
    check_output("stat_first", 32'(f[1]), 32'h60);
    apply_stimulus('{8'h40, 8'h00}, f);
    model_frame('{8'h40, 8'h00});
    check_output("stat_second", 32'(f[1]), 32'h20);

    for (int it = 0; it < 25; it++) begin
      set_busy(1'($urandom_range(0, 1)));
      case ($urandom_range(0, 4))
        0: cmd = 8'h10;
        1: cmd = 8'h20;
        2: cmd = 8'h30;
        3: cmd = 8'h40;
        default: begin
          cmd = u8_t'($urandom);
          while (cmd inside {8'h10, 8'h20, 8'h30, 8'h40}) cmd = u8_t'($urandom);
        end
      endcase
      tail = (cmd == 8'h10 || cmd == 8'h20) ? $urandom_range(0, 34) : $urandom_range(0, 3);
      f = {cmd};
      for (int k = 0; k < tail; k++) f.push_back(u8_t'($urandom));
      run_frame($sformatf("rand%0d", it), f);
      run_frame($sformatf("rand%0d.stat", it), '{8'h40, 8'h00, 8'h00});
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
